// File: rtl/abm_multi_ctl_if.sv
// AXI4-Lite slave bus bundle for abm_multi_ctl.
//   AW : address width (bits)
// Channels: AW/W/B write path and AR/R read path, 32-bit data.
// Modports: master drives requests, slave drives ready/response signals.
interface abm_multi_ctl_if #(
    parameter int AW = 8
);
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/abm_multi_ctl.sv
// abm_multi_ctl: AXI4-Lite control/status block for up to 8 ABM loader channels.
// Optional feature macro: ABM_WATCHDOG_EN (per-channel watchdog counters).
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   load[NCH]          one-cycle launch pulse per channel
//   idle[NCH]          1 = loader channel idle
//   pci_src_addr       channel i source address at [64i+63:64i]
//   select_hsi         1 = SMEM writes via HSI, 0 = via SPI
//   force_smem_update  level, rising edge forces full SMEM update
//   hs_clk_div_out     HS clock divider word; hs_clk_configure pulses after a write
//   hs_clk_div_in/vco_in readback from clock wizard
//   irq                level interrupt |(STATUS & IRQ_EN), registered
//   ch_state_dbg       per-channel FSM state, 2 bits per channel
//   s_axi              AXI4-Lite slave (PROT and WSTRB ignored)
module abm_multi_ctl #(
    parameter int          AW        = 8,
    parameter int          NCH       = 4,
    parameter logic [63:0] ADDR_RST  = 64'h1_0000_0000,
    parameter int          WD_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               resetn,
    output logic [NCH-1:0]     load,
    input  logic [NCH-1:0]     idle,
    output logic [64*NCH-1:0]  pci_src_addr,
    output logic               select_hsi,
    output logic               force_smem_update,
    output logic [31:0]        hs_clk_div_out,
    output logic               hs_clk_configure,
    input  logic [31:0]        hs_clk_div_in,
    input  logic [31:0]        hs_clk_vco_in,
    output logic               irq,
    output logic [2*NCH-1:0]   ch_state_dbg,
    abm_multi_ctl_if.slave     s_axi
);
    localparam int IW = AW - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_RUN = 2'd2} ch_state_e;

    ch_state_e        st_q [NCH];
    ch_state_e        st_d [NCH];
    logic [NCH-1:0]   load_q, load_d;
    logic [NCH-1:0]   done_q, reject_q, timeout_q;
    logic [NCH-1:0]   done_set, reject_set, timeout_set, wd_hit;
    logic [NCH-1:0]   ie_done_q, ie_rej_q, ie_to_q;
    logic [63:0]      addr_q [NCH];
    logic             sel_q, force_q, cfg_q, irq_q;
    logic [31:0]      div_q;
    logic             awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]       bresp_q, rresp_q;
    logic [31:0]      rdata_q, rd_data;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic             wr_en, rd_en, status_w1c;
    logic [NCH-1:0]   load_req, w1c_done, w1c_rej, w1c_to;
    logic [7:0]       busy8, done8, rej8, to8, ie_done8, ie_rej8, ie_to8;
    logic             unused_ok;

    // Handshake: a beat transfers on any edge where VALID and READY are both
    // high; VALID holds until then, READY pulses one cycle (registered), and
    // B/R responses hold VALID until the master's READY.
    assign wr_idx = s_axi.awaddr[AW-1:2];
    assign rd_idx = s_axi.araddr[AW-1:2];
    assign wr_en  = awready_q & s_axi.awvalid & s_axi.wvalid;
    assign rd_en  = arready_q & s_axi.arvalid;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.wstrb,
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    function automatic logic idx_mapped(input logic [IW-1:0] idx);
        int v;
        v = int'(idx);
        return (v <= 5) || ((v >= 8) && (v < 8 + 2 * NCH));
    endfunction

    assign load_req   = (wr_en && int'(wr_idx) == 0) ? s_axi.wdata[NCH-1:0] : '0;
    assign status_w1c = wr_en && int'(wr_idx) == 1;
    assign w1c_done   = status_w1c ? s_axi.wdata[0 +: NCH]  : '0;
    assign w1c_rej    = status_w1c ? s_axi.wdata[8 +: NCH]  : '0;
    assign w1c_to     = status_w1c ? s_axi.wdata[16 +: NCH] : '0;

`ifdef ABM_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);
    logic [WDW-1:0] wd_cnt_q [NCH];

    // Counter restarts at launch; the WD_CYCLES-th cycle spent in
    // START/RUN is the one that trips.
    always_comb begin
        for (int i = 0; i < NCH; i++)
            wd_hit[i] = (st_q[i] != ST_IDLE) && (wd_cnt_q[i] == WDW'(WD_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) wd_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load_d[i])                wd_cnt_q[i] <= '0;
                else if (st_q[i] != ST_IDLE)  wd_cnt_q[i] <= wd_cnt_q[i] + 1'b1;
            end
        end
    end
`else
    assign wd_hit = '0;
`endif

    // Channel FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) st_q[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < NCH; i++) st_q[i] <= st_d[i];
        end
    end

    // Channel FSM: next state
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_d[i] = st_q[i];
            case (st_q[i])
                ST_IDLE:  if (load_req[i] && idle[i]) st_d[i] = ST_START;
                ST_START: if (wd_hit[i]) st_d[i] = ST_IDLE;
                          else if (!idle[i]) st_d[i] = ST_RUN;
                ST_RUN:   if (idle[i] || wd_hit[i]) st_d[i] = ST_IDLE;
                default:  st_d[i] = ST_IDLE;
            endcase
        end
    end

    // Channel FSM: outputs and status events (finishing beats a watchdog trip)
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            load_d[i]      = (st_q[i] == ST_IDLE) && load_req[i] && idle[i];
            reject_set[i]  = load_req[i] && !((st_q[i] == ST_IDLE) && idle[i]);
            done_set[i]    = (st_q[i] == ST_RUN) && idle[i];
            timeout_set[i] = wd_hit[i] && !done_set[i];
        end
    end

    always_comb begin
        busy8 = '0; done8 = '0; rej8 = '0; to8 = '0;
        ie_done8 = '0; ie_rej8 = '0; ie_to8 = '0;
        for (int i = 0; i < NCH; i++) begin
            busy8[i] = (st_q[i] != ST_IDLE) | ~idle[i];
            ch_state_dbg[2*i +: 2] = st_q[i];
            pci_src_addr[64*i +: 64] = addr_q[i];
        end
        done8[NCH-1:0]    = done_q;
        rej8[NCH-1:0]     = reject_q;
        to8[NCH-1:0]      = timeout_q;
        ie_done8[NCH-1:0] = ie_done_q;
        ie_rej8[NCH-1:0]  = ie_rej_q;
        ie_to8[NCH-1:0]   = ie_to_q;
    end

    always_comb begin
        rd_data = '0;
        case (int'(rd_idx))
            0:       rd_data = {24'd0, busy8};
            1:       rd_data = {8'd0, to8, rej8, done8};
            2:       rd_data = {8'd0, ie_to8, ie_rej8, ie_done8};
            3:       rd_data = {30'd0, force_q, sel_q};
            4:       rd_data = hs_clk_vco_in;
            5:       rd_data = hs_clk_div_in;
            default: rd_data = '0;
        endcase
        for (int i = 0; i < NCH; i++) begin
            if (int'(rd_idx) == 8 + 2 * i) rd_data = addr_q[i][63:32];
            if (int'(rd_idx) == 9 + 2 * i) rd_data = addr_q[i][31:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_q <= '0; done_q <= '0; reject_q <= '0; timeout_q <= '0;
            ie_done_q <= '0; ie_rej_q <= '0; ie_to_q <= '0;
            for (int i = 0; i < NCH; i++) addr_q[i] <= ADDR_RST;
            sel_q <= 1'b1; force_q <= 1'b0; cfg_q <= 1'b0; irq_q <= 1'b0;
            div_q <= '0;
            awready_q <= 1'b0; bvalid_q <= 1'b0; bresp_q <= RESP_OKAY;
            arready_q <= 1'b0; rvalid_q <= 1'b0; rresp_q <= RESP_OKAY;
            rdata_q <= '0;
        end else begin
            load_q    <= load_d;
            // set events override a same-cycle write-1-to-clear
            done_q    <= (done_q & ~w1c_done) | done_set;
            reject_q  <= (reject_q & ~w1c_rej) | reject_set;
            timeout_q <= (timeout_q & ~w1c_to) | timeout_set;
            irq_q     <= |({timeout_q, reject_q, done_q} & {ie_to_q, ie_rej_q, ie_done_q});
            cfg_q     <= wr_en && int'(wr_idx) == 5;

            if (wr_en) begin
                case (int'(wr_idx))
                    2: begin
                        ie_done_q <= s_axi.wdata[0 +: NCH];
                        ie_rej_q  <= s_axi.wdata[8 +: NCH];
                        ie_to_q   <= s_axi.wdata[16 +: NCH];
                    end
                    3: begin
                        sel_q   <= s_axi.wdata[0];
                        force_q <= s_axi.wdata[1];
                    end
                    5:       div_q <= s_axi.wdata;
                    default: ;
                endcase
                for (int i = 0; i < NCH; i++) begin
                    if (int'(wr_idx) == 8 + 2 * i) addr_q[i][63:32] <= s_axi.wdata;
                    if (int'(wr_idx) == 9 + 2 * i) addr_q[i][31:0]  <= s_axi.wdata;
                end
            end

            awready_q <= !awready_q && s_axi.awvalid && s_axi.wvalid && !bvalid_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= idx_mapped(wr_idx) ? RESP_OKAY : RESP_DECERR;
            end else if (s_axi.bready) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= !arready_q && s_axi.arvalid && !rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= idx_mapped(rd_idx) ? RESP_OKAY : RESP_DECERR;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign load              = load_q;
    assign select_hsi        = sel_q;
    assign force_smem_update = force_q;
    assign hs_clk_div_out    = div_q;
    assign hs_clk_configure  = cfg_q;
    assign irq               = irq_q;
    assign s_axi.awready     = awready_q;
    assign s_axi.wready      = awready_q;
    assign s_axi.bvalid      = bvalid_q;
    assign s_axi.bresp       = bresp_q;
    assign s_axi.arready     = arready_q;
    assign s_axi.rvalid      = rvalid_q;
    assign s_axi.rresp       = rresp_q;
    assign s_axi.rdata       = rdata_q;
endmodule

// File: tb/tb_abm_multi_ctl.sv
// Self-checking bench for abm_multi_ctl (AW=8, NCH=4). The loader is played
// by the bench through idle[]; expected status/busy/irq come from a small
// per-channel bit model updated from the register rules.
module tb_abm_multi_ctl;
    localparam int          AW       = 8;
    localparam int          NCH      = 4;
    localparam logic [63:0] ADDR_RST = 64'h1_0000_0000;
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  DECERR   = 2'b11;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [NCH-1:0]     load;
    logic [NCH-1:0]     idle;
    logic [64*NCH-1:0]  pci_src_addr;
    logic               select_hsi, force_smem_update, hs_clk_configure, irq;
    logic [31:0]        hs_clk_div_out, hs_clk_div_in, hs_clk_vco_in;
    logic [2*NCH-1:0]   ch_state_dbg;

    abm_multi_ctl_if #(.AW(AW)) axi ();

    abm_multi_ctl #(.AW(AW), .NCH(NCH), .ADDR_RST(ADDR_RST), .WD_CYCLES(100)) dut (
        .clk(clk), .resetn(resetn), .load(load), .idle(idle),
        .pci_src_addr(pci_src_addr), .select_hsi(select_hsi),
        .force_smem_update(force_smem_update), .hs_clk_div_out(hs_clk_div_out),
        .hs_clk_configure(hs_clk_configure), .hs_clk_div_in(hs_clk_div_in),
        .hs_clk_vco_in(hs_clk_vco_in), .irq(irq), .ch_state_dbg(ch_state_dbg),
        .s_axi(axi.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int load_cnt [NCH];
    int cfg_cnt = 0;

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) if (load[i] === 1'b1) load_cnt[i]++;
        if (hs_clk_configure === 1'b1) cfg_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s observed=no handshake expected=handshake", tag);
    endtask

    task automatic clr_loads();
        for (int i = 0; i < NCH; i++) load_cnt[i] = 0;
    endtask

    function automatic logic [31:0] packed_loads();
        logic [31:0] r = '0;
        for (int i = 0; i < NCH; i++) r[8*i +: 8] = 8'(load_cnt[i]);
        return r;
    endfunction

    function automatic logic [31:0] expect_loads(input logic [NCH-1:0] m);
        logic [31:0] r = '0;
        for (int i = 0; i < NCH; i++) r[8*i +: 8] = m[i] ? 8'd1 : 8'd0;
        return r;
    endfunction

    task automatic wait_b(output logic [1:0] resp);
        bit seen = 0;
        resp = 2'bxx;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (axi.bvalid && axi.bready) begin seen = 1; resp = axi.bresp; break; end
        end
        @(posedge clk); #1;
        if (!seen) tmo("b_timeout");
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, output logic [1:0] resp);
        bit seen = 0;
        axi.awaddr = a; axi.wdata = d; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (axi.awready && axi.wready) begin seen = 1; break; end
        end
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        if (!seen) tmo("aw_timeout");
        wait_b(resp);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit seen = 0;
        d = 'x; resp = 2'bxx;
        axi.araddr = a; axi.arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (axi.arready) begin seen = 1; break; end
        end
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        if (!seen) tmo("ar_timeout");
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (axi.rvalid) begin seen = 1; d = axi.rdata; resp = axi.rresp; break; end
        end
        @(posedge clk); #1;
        if (!seen) tmo("r_timeout");
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        chk({tag, "_data"}, 64'(d), 64'(exp));
        chk({tag, "_resp"}, 64'(r), 64'(OKAY));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_write(a, d, r);
        chk("wr_resp", 64'(r), 64'(OKAY));
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [63:0]    exp_addr [NCH];
        logic [NCH-1:0] exp_done, exp_rej, exp_busy, ie_done, ie_rej, m, launch, fin;
        logic [31:0]    d, w;
        logic [1:0]     r;

        axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0; axi.bready = 1; axi.rready = 1;
        axi.awaddr = '0; axi.wdata = '0; axi.wstrb = '0; axi.araddr = '0;
        axi.awprot = '0; axi.arprot = '0;
        idle = '1; hs_clk_div_in = 32'h1234_5678; hs_clk_vco_in = 32'hCAFE_0001;
        clr_loads();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // ---- reset state ----
        chk("rst_load", 64'(load), 0);
        chk("rst_irq", 64'(irq), 0);
        chk("rst_sel", 64'(select_hsi), 1);
        chk("rst_force", 64'(force_smem_update), 0);
        chk("rst_div", 64'(hs_clk_div_out), 0);
        chk("rst_bvalid", 64'(axi.bvalid), 0);
        chk("rst_rvalid", 64'(axi.rvalid), 0);
        for (int i = 0; i < NCH; i++) begin
            exp_addr[i] = ADDR_RST;
            chk("rst_addr", pci_src_addr[64*i +: 64], ADDR_RST);
        end
        rd_chk("rst_src_h0", 8'h20, 32'h1);
        rd_chk("rst_src_l0", 8'h24, 32'h0);
        rd_chk("rst_ctrl", 8'h0C, 32'h1);
        rd_chk("rst_busy", 8'h00, 32'h0);
        rd_chk("rst_status", 8'h04, 32'h0);
        rd_chk("rst_irqen", 8'h08, 32'h0);

        // ---- source addresses ----
        wr(8'h28, 32'h0000_DEAD);
        wr(8'h2C, 32'hBEEF_0000);
        exp_addr[1] = 64'h0000_DEAD_BEEF_0000;
        chk("addr1_out", pci_src_addr[127:64], 64'h0000_DEAD_BEEF_0000);
        rd_chk("addr1_h", 8'h28, 32'h0000_DEAD);
        rd_chk("addr1_l", 8'h2C, 32'hBEEF_0000);
        for (int i = 0; i < NCH; i++) begin
            exp_addr[i] = {$urandom, $urandom};
            wr(8'(32 + 8 * i), exp_addr[i][63:32]);
            wr(8'(36 + 8 * i), exp_addr[i][31:0]);
        end
        for (int i = 0; i < NCH; i++) begin
            chk("addr_out", pci_src_addr[64*i +: 64], exp_addr[i]);
            rd_chk("addr_rd_h", 8'(32 + 8 * i), exp_addr[i][63:32]);
            rd_chk("addr_rd_l", 8'(36 + 8 * i), exp_addr[i][31:0]);
        end

        // ---- HS clock registers ----
        cfg_cnt = 0;
        wr(8'h14, 32'h0000_0A05);
        repeat (3) @(negedge clk);
        chk("div_out", 64'(hs_clk_div_out), 64'h0A05);
        chk("cfg_pulses", 64'(cfg_cnt), 1);
        rd_chk("div_in", 8'h14, 32'h1234_5678);
        rd_chk("vco_in", 8'h10, 32'hCAFE_0001);

        // ---- CTRL ----
        wr(8'h0C, 32'h2);
        chk("ctrl_sel", 64'(select_hsi), 0);
        chk("ctrl_force", 64'(force_smem_update), 1);
        rd_chk("ctrl_rd", 8'h0C, 32'h2);
        wr(8'h0C, 32'h1);

        // ---- unmapped indices ----
        axi_read(8'h40, d, r);
        chk("decerr_rd40", 64'(r), 64'(DECERR));
        axi_read(8'h18, d, r);
        chk("decerr_rd18", 64'(r), 64'(DECERR));
        axi_write(8'h40, 32'hFFFF_FFFF, r);
        chk("decerr_wr40", 64'(r), 64'(DECERR));
        axi_write(8'hFC, 32'hFFFF_FFFF, r);
        chk("decerr_wrfc", 64'(r), 64'(DECERR));
        chk("decerr_noside_sel", 64'(select_hsi), 1);
        chk("decerr_noside_div", 64'(hs_clk_div_out), 64'h0A05);
        for (int i = 0; i < NCH; i++)
            chk("decerr_noside_addr", pci_src_addr[64*i +: 64], exp_addr[i]);

        // ---- launch, done, irq, W1C ----
        clr_loads();
        wr(8'h00, 32'h5);
        idle[0] = 1'b0; idle[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("launch5_pulses", 64'(packed_loads()), 64'(expect_loads(4'b0101)));
        repeat (8) @(negedge clk);
        rd_chk("launch5_busy", 8'h00, 32'h5);
        idle = '1;
        repeat (3) @(negedge clk);
        rd_chk("launch5_status", 8'h04, 32'h05);
        chk("irq_masked", 64'(irq), 0);
        wr(8'h08, 32'h05);
        repeat (2) @(negedge clk);
        chk("irq_on", 64'(irq), 1);
        wr(8'h04, 32'h01);
        rd_chk("w1c_1", 8'h04, 32'h04);
        wr(8'h04, 32'h04);
        repeat (2) @(negedge clk);
        chk("irq_off", 64'(irq), 0);

        // ---- reject while running ----
        clr_loads();
        wr(8'h00, 32'h2);
        idle[1] = 1'b0;
        repeat (3) @(negedge clk);
        wr(8'h00, 32'h2);
        repeat (2) @(negedge clk);
        chk("rej_pulses", 64'(packed_loads()), 64'(expect_loads(4'b0010)));
        rd_chk("rej_status", 8'h04, 32'h200);
        idle = '1;
        repeat (3) @(negedge clk);
        rd_chk("rej_done", 8'h04, 32'h202);
        wr(8'h04, 32'hFFFF_FFFF);

        // ---- bits above NCH ----
        clr_loads();
        wr(8'h00, 32'hF0);
        repeat (2) @(negedge clk);
        chk("hi_bits_pulses", 64'(packed_loads()), 0);
        rd_chk("hi_bits_status", 8'h04, 32'h0);
        wr(8'h08, 32'hFFFF_FFFF);
`ifdef ABM_WATCHDOG_EN
        rd_chk("irqen_mask", 8'h08, 32'h000F_0F0F);
`else
        rd_chk("irqen_mask", 8'h08, 32'h000F_0F0F);
`endif

        // ---- BREADY back-pressure ----
        axi.bready = 1'b0;
        axi.awaddr = 8'h0C; axi.wdata = 32'h1; axi.awvalid = 1; axi.wvalid = 1;
        begin
            bit seen = 0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (axi.awready) begin seen = 1; break; end
            end
            @(posedge clk); #1;
            if (!seen) tmo("bp_aw_timeout");
        end
        axi.wdata = 32'h0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_bvalid", 64'(axi.bvalid), 1);
            chk("bp_awready", 64'(axi.awready), 0);
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi_write(8'h0C, 32'h0, r);
        chk("bp_second_resp", 64'(r), 64'(OKAY));
        chk("bp_second_sel", 64'(select_hsi), 0);
        wr(8'h0C, 32'h1);

        // ---- randomized launches against the bit model ----
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h08, 32'h0);
        exp_done = '0; exp_rej = '0; exp_busy = '0; ie_done = '0; ie_rej = '0;
        idle = '1;
        for (int it = 0; it < 40; it++) begin
            fin = exp_busy & 4'($urandom_range(0, 15));
            @(negedge clk);
            idle = idle | fin;
            repeat (3) @(negedge clk);
            exp_done = exp_done | fin;
            exp_busy = exp_busy & ~fin;

            w = 32'($urandom_range(0, 255));
            m = w[NCH-1:0];
            launch = m & ~exp_busy;
            clr_loads();
            wr(8'h00, w);
            idle = idle & ~launch;
            repeat (2) @(negedge clk);
            chk("rnd_pulses", 64'(packed_loads()), 64'(expect_loads(launch)));
            exp_rej  = exp_rej | (m & exp_busy);
            exp_busy = exp_busy | launch;

            if ($urandom_range(0, 3) == 0) begin
                w = $urandom;
                wr(8'h04, w);
                exp_done = exp_done & ~w[NCH-1:0];
                exp_rej  = exp_rej & ~w[8 +: NCH];
            end
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom;
                wr(8'h08, w);
                ie_done = w[NCH-1:0];
                ie_rej  = w[8 +: NCH];
            end
            rd_chk("rnd_status", 8'h04, {16'd0, 4'd0, exp_rej, 4'd0, exp_done});
            rd_chk("rnd_busy", 8'h00, {28'd0, exp_busy});
            chk("rnd_irq", 64'(irq), 64'(|((exp_done & ie_done) | (exp_rej & ie_rej))));
        end
        idle = '1;
        repeat (3) @(negedge clk);

`ifdef ABM_WATCHDOG_EN
        // ---- watchdog: loader never finishes ----
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h00, 32'h8);
        idle[3] = 1'b0;
        repeat (120) @(negedge clk);
        rd_chk("wd_status", 8'h04, 32'h0008_0000);
        rd_chk("wd_busy_stuck", 8'h00, 32'h8);
        idle = '1;
        repeat (2) @(negedge clk);
        rd_chk("wd_busy_clear", 8'h00, 32'h0);
`endif

        // ---- asynchronous reset mid-run ----
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h08, 32'h000F_0F0F);
        wr(8'h00, 32'h1);
        idle[0] = 1'b0;
        repeat (3) @(negedge clk);
        wr(8'h00, 32'h1);
        repeat (3) @(negedge clk);
        chk("pre_rst_irq", 64'(irq), 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_load", 64'(load), 0);
        chk("arst_irq", 64'(irq), 0);
        chk("arst_sel", 64'(select_hsi), 1);
        chk("arst_div", 64'(hs_clk_div_out), 0);
        chk("arst_fsm", 64'(ch_state_dbg), 0);
        for (int i = 0; i < NCH; i++)
            chk("arst_addr", pci_src_addr[64*i +: 64], ADDR_RST);
        idle = '1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        rd_chk("arst_busy", 8'h00, 32'h0);
        rd_chk("arst_status", 8'h04, 32'h0);
        rd_chk("arst_irqen", 8'h08, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
